// File: rtl/display_scroll_controller.sv
// display_scroll_controller
// Drives the four-digit seven-segment display: refreshes digits 3,2,1,0 with an
// all-anodes-off gap before each digit. It scrolls a 16-entry character buffer
// across the digits once every SCROLL_STEPS frames. Writes into the buffer go
// through a valid/ready port that is only open while no digit is lit.
module display_scroll_controller #(
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 50,
    parameter int SCROLL_STEPS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_char,
    output logic       wr_ready,
    input  logic       pause,
    output logic [3:0] anode_n,
    output logic [3:0] char,
    output logic [1:0] digit_idx,
    output logic [3:0] scroll_pos,
    output logic       frame_tick
);

    // One phase counter serves both states, so it is sized for the longer one.
    localparam int PH_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int FC_W   = (SCROLL_STEPS > 1) ? $clog2(SCROLL_STEPS) : 1;

    localparam logic [PH_W-1:0] BLANK_LAST = PH_W'(BLANK_CYCLES - 1);
    localparam logic [PH_W-1:0] DIGIT_LAST = PH_W'(DIGIT_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_LAST    = FC_W'(SCROLL_STEPS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [1:0]      digit_q, digit_d;
    logic [FC_W-1:0] fc_q, fc_d;
    logic [3:0]      scroll_q, scroll_d;
    logic            frame_end;

    logic [3:0]      msg_q [16];
    logic [3:0]      anode_q, anode_d;
    logic [3:0]      char_q, char_d;
    logic            tick_q, tick_d;

    logic            wr_fire;
    logic [3:0]      sel_idx;
    logic [3:0]      sel_char;

    // The buffer is writable only while every anode is off, so a lit digit never changes.
    assign wr_ready = reset && (state_q == ST_BLANK);
    assign wr_fire  = wr_valid && wr_ready;

    // State register: FSM, phase, digit, frame and scroll counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_BLANK;
            phase_q  <= '0;
            digit_q  <= 2'd3;
            fc_q     <= '0;
            scroll_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            digit_q  <= digit_d;
            fc_q     <= fc_d;
            scroll_q <= scroll_d;
        end
    end

    // Next-state logic: blank/drive alternation, digit rotation, frame and scroll stepping.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + 1'b1;
        digit_d   = digit_q;
        fc_d      = fc_q;
        scroll_d  = scroll_q;
        frame_end = 1'b0;
        unique case (state_q)
            ST_BLANK: begin
                if (phase_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    phase_d = '0;
                end
            end
            ST_DRIVE: begin
                if (phase_q == DIGIT_LAST) begin
                    state_d   = ST_BLANK;
                    phase_d   = '0;
                    digit_d   = digit_q - 2'd1;   // 0 wraps to 3
                    frame_end = (digit_q == 2'd0);
                end
            end
        endcase
        // pause only holds the scroll position; frame counting carries on
        if (frame_end) begin
            if (fc_q == FC_LAST) begin
                fc_d = '0;
                if (!pause) begin
                    scroll_d = scroll_q + 4'd1;
                end
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    // Output logic: registered outputs are computed from the next state so anodes and char switch together.
    always_comb begin
        sel_idx  = scroll_d + 4'd3 - {2'b00, digit_d};
        // a write landing on the edge that enters DRIVE must already be visible
        sel_char = (wr_fire && (wr_addr == sel_idx)) ? wr_char : msg_q[sel_idx];
        anode_d  = 4'b1111;
        char_d   = 4'd0;
        if (state_d == ST_DRIVE) begin
            anode_d[digit_d] = 1'b0;
            char_d           = sel_char;
        end
        tick_d = frame_end;
    end

    // Output registers and the message buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            anode_q <= 4'b1111;
            char_q  <= 4'd0;
            tick_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                msg_q[i] <= 4'd0;
            end
        end else begin
            anode_q <= anode_d;
            char_q  <= char_d;
            tick_q  <= tick_d;
            if (wr_fire) begin
                msg_q[wr_addr] <= wr_char;
            end
        end
    end

    assign anode_n    = anode_q;
    assign char       = char_q;
    assign digit_idx  = digit_q;
    assign scroll_pos = scroll_q;
    assign frame_tick = tick_q;

endmodule
